sa_ram_rwsthp_param: RTL
========================

Name: sa_ram_rwsthp_param

Overview:
Parametrised successor of the fixed-size 1R1W synchronous-read RAM model used in the systolic-array buffers.
- One write port and one read port; read address registered on re; output registered on ore; external bypass mux in front of the output register.
- Adds a post-reset zero-initialisation sequencer, a read-valid tracker and sticky out-of-range address error detection.
- Serves as the FPGA behavioural model for every sa_ram_rwsthp_<D>x<W> instance size.

Parameters:
WIDTH, 80, data width in bits
DEPTH, 19, number of words (>=2)
AW, 5, address width; must satisfy 2**AW >= DEPTH

Ports:
clk  input  1  clock; all state on rising edge
rstn  input  1  reset, asynchronous assert, active-low
ra  input  AW  read address
re  input  1  read enable; captures ra
ore  input  1  output register enable
dout  output  WIDTH  registered read data
wa  input  AW  write address
we  input  1  write enable
di  input  WIDTH  write data
byp_sel  input  1  select dbyp instead of array data into the output register
dbyp  input  WIDTH  bypass data
pwrbus_ram_pd  input  32  power-down bus; accepted, functionally ignored
init_busy  output  1  high while the zero-init sweep runs
dout_vld  output  1  dout holds a completed read or bypass value
addr_err  output  1  sticky: an out-of-range address was used

Behaviour:
Reset values (rstn low):
- ra_d=0, dout=0, dout_vld=0, addr_err=0, init pointer=0.
- init_busy=1; FSM state INIT.
- Array contents are not reset directly; the sequencer clears them.

Init FSM, two states:
- INIT: each cycle write 0 to M[ptr]; ptr increments by 1. When ptr==DEPTH-1, that write completes and the FSM moves to READY. INIT therefore lasts exactly DEPTH cycles after rstn rises.
- READY: terminal state; init_busy=0.
- rstn asserted mid-INIT or in READY: asynchronously returns to INIT with ptr=0. The sweep restarts from 0.
- During INIT, user we and re are ignored: no array write, ra_d unchanged, no addr_err update. ore and byp_sel still operate.

Write:
- In READY with we=1 and wa<DEPTH: M[wa]<=di at the clock edge.
- wa>=DEPTH: write dropped and addr_err<=1.

Read pipeline:
- Cycle N: re=1 in READY -> ra_d<=ra and rd_pend<=1.
- Cycle N+1: array output M[ra_d] is combinational.
- ore=1 in cycle N+1 -> dout is updated at the N+1 edge. Minimum read latency is 2 edges from re.
- ra_d>=DEPTH: array output reads 0; addr_err<=1 when that re is accepted.
- Array output holds while ra_d is unchanged. ore may be delayed any number of cycles and captures the current M[ra_d], including writes that have landed since.

Output register (ore=1):
- dout <= byp_sel ? dbyp : array_out.
- dout_vld <= byp_sel | rd_pend.
- rd_pend clears on ore, unless re is accepted in the same cycle, which keeps it set.
- ore=0: dout, dout_vld and rd_pend hold.

Read/write collision:
- ore=1 and we=1 with wa==ra_d in the same cycle: dout captures OLD data (pre-write) unless SA_RAM_RDW_FWD_EN is defined.
- wa==ra in the same cycle as re: no interaction; the address is simply registered.

addr_err: sticky; cleared only by rstn.

Optional Feature:
SA_RAM_RDW_FWD_EN
- Defined: when ore=1, byp_sel=0, we=1 (READY), wa==ra_d and wa<DEPTH, dout captures di (write-through forwarding). byp_sel still takes priority over forwarding.
- Undefined: old-data behaviour described above. No extra compare logic is built.

Test Plan:
- Release rstn with WIDTH=80, DEPTH=19 -> init_busy high for exactly 19 cycles. Then read every address with re followed by ore -> dout=0 and dout_vld=1 for each.
- Write M[7]=0x1234 in READY; re ra=7 at N; ore at N+1 -> dout=0x1234 after the N+1 edge. ore held off until N+5 -> same value; dout_vld=0 until the ore edge (from reset).
- we wa=20 (>=DEPTH) -> no array change; addr_err=1 and stays 1 through subsequent traffic until rstn pulses low.
- byp_sel=1, dbyp=0xABCD, ore=1 with no pending read -> dout=0xABCD, dout_vld=1. Next ore with byp_sel=0 and no re -> dout_vld=0.
- M[3]=0x5; re ra=3; next cycle ore=1 with we wa=3 di=0x9 -> dout=0x5 without SA_RAM_RDW_FWD_EN, dout=0x9 with it. A following re/ore pair returns 0x9 in both builds.
- Assert rstn low at init ptr=10, release -> init_busy high for 19 further cycles. A write attempted during that window is lost (reads back 0).

Source files
------------

// File: rtl/sa_ram_rwsthp_param_if.sv
// Port bundle for sa_ram_rwsthp_param: read/write ports, output register
// controls, bypass path and status flags.
interface sa_ram_rwsthp_param_if #(
    parameter int WIDTH = 80,
    parameter int AW    = 5
);
    logic [AW-1:0]    ra;
    logic             re;
    logic             ore;
    logic [WIDTH-1:0] dout;
    logic [AW-1:0]    wa;
    logic             we;
    logic [WIDTH-1:0] di;
    logic             byp_sel;
    logic [WIDTH-1:0] dbyp;
    logic [31:0]      pwrbus_ram_pd;
    logic             init_busy;
    logic             dout_vld;
    logic             addr_err;

    modport master (
        output ra, re, ore, wa, we, di, byp_sel, dbyp, pwrbus_ram_pd,
        input  dout, init_busy, dout_vld, addr_err
    );

    modport slave (
        input  ra, re, ore, wa, we, di, byp_sel, dbyp, pwrbus_ram_pd,
        output dout, init_busy, dout_vld, addr_err
    );
endinterface

// File: rtl/sa_ram_rwsthp_param.sv
// Parametrised 1R1W sync-read RAM with post-reset zero sweep, read-valid
// tracking and sticky address error. Define SA_RAM_RDW_FWD_EN for write-through.
module sa_ram_rwsthp_param #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 19,
    parameter int AW    = 5
) (
    input logic                  clk,
    input logic                  rstn,
    sa_ram_rwsthp_param_if.slave bus
);
    localparam int             IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  LAST    = AW'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t           state;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ra_d;
    logic             rd_pend;
    logic [WIDTH-1:0] dout_q;
    logic             dout_vld_q;
    logic             addr_err_q;
    logic             init_busy_q;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             ready, re_acc, we_acc;
    logic             wa_ok, ra_ok, rad_ok;
    logic [WIDTH-1:0] array_out, dout_nxt;
    logic             mem_we;
    logic [IW-1:0]    mem_idx;
    logic [WIDTH-1:0] mem_d;
    logic             unused_pd;

    assign unused_pd = ^bus.pwrbus_ram_pd;

    assign ready  = (state == READY);
    assign re_acc = ready & bus.re;
    assign we_acc = ready & bus.we;
    assign wa_ok  = {1'b0, bus.wa} < DEPTH_W;
    assign ra_ok  = {1'b0, bus.ra} < DEPTH_W;
    assign rad_ok = {1'b0, ra_d}   < DEPTH_W;

    assign array_out = rad_ok ? mem[ra_d[IW-1:0]] : '0;

`ifdef SA_RAM_RDW_FWD_EN
    logic fwd_hit;
    assign fwd_hit  = we_acc & wa_ok & (bus.wa == ra_d);
    assign dout_nxt = bus.byp_sel ? bus.dbyp : (fwd_hit ? bus.di : array_out);
`else
    assign dout_nxt = bus.byp_sel ? bus.dbyp : array_out;
`endif

    // The sweep owns the single write port until READY.
    assign mem_we  = ready ? (we_acc & wa_ok) : 1'b1;
    assign mem_idx = ready ? bus.wa[IW-1:0] : ptr[IW-1:0];
    assign mem_d   = ready ? bus.di : '0;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= INIT;
            ptr         <= '0;
            init_busy_q <= 1'b1;
            ra_d        <= '0;
            rd_pend     <= 1'b0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (ptr == LAST) begin
                        state       <= READY;
                        init_busy_q <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: ;
            endcase

            // A read accepted alongside ore keeps the pending flag for its own ore.
            if (re_acc) begin
                ra_d    <= bus.ra;
                rd_pend <= 1'b1;
            end else if (bus.ore) begin
                rd_pend <= 1'b0;
            end

            if ((re_acc & ~ra_ok) | (we_acc & ~wa_ok)) addr_err_q <= 1'b1;

            if (bus.ore) begin
                dout_q     <= dout_nxt;
                dout_vld_q <= bus.byp_sel | rd_pend;
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.addr_err  = addr_err_q;
    assign bus.init_busy = init_busy_q;
endmodule
